// File: rtl/gemac_fifo36_pkg.sv
// rtl/gemac_fifo36_pkg.sv - shared 36-bit GEMAC TX FIFO word layout and occupancy decode
package gemac_fifo36_pkg;

    localparam int F36_W      = 36;
    localparam int F36_SOF    = 32;
    localparam int F36_EOF    = 33;
    localparam int F36_OCC_LO = 34;
    localparam int F36_OCC_HI = 35;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FRAME = 1'b1
    } ll_state_e;

    // occ counts valid bytes in an EOF word, with 0 meaning all four.
    function automatic logic [1:0] occ_to_last_idx(input logic [1:0] occ);
        return occ - 2'd1;
    endfunction

endpackage

// File: rtl/fifo36_to_ll8_tx.sv
// rtl/fifo36_to_ll8_tx.sv - pops 36-bit TX FIFO words and serialises them into an 8-bit LocalLink stream
module fifo36_to_ll8_tx
    import gemac_fifo36_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [F36_W-1:0] fifo_dout,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    output logic [7:0]       ll_data,
    output logic             ll_sof,
    output logic             ll_eof,
    output logic             ll_err,
    output logic             ll_src_rdy,
    input  logic             ll_dst_rdy,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] drop_cnt
);

    ll_state_e  state, state_nxt;
    logic       word_vld;
    logic       active;
    logic [1:0] byte_idx;
    logic [1:0] last_idx;
    logic [1:0] byte_sel;
    logic       w_sof, w_eof;
    logic       last, xfer, end_xfer, discard;

    // fifo_dout is the word register: it holds until the next pop.
    assign w_sof    = fifo_dout[F36_SOF];
    assign w_eof    = fifo_dout[F36_EOF];
    assign last_idx = w_eof ? occ_to_last_idx(fifo_dout[F36_OCC_HI:F36_OCC_LO]) : 2'd3;
    assign last     = (byte_idx == last_idx);
    assign xfer     = ll_src_rdy & ll_dst_rdy;
    assign end_xfer = last & xfer;
    assign discard  = word_vld & (state == ST_IDLE) & ~w_sof;
    assign byte_sel = BIG_ENDIAN ? ~byte_idx : byte_idx;

    // Popping on the last-byte handshake keeps words back to back; active holds
    // off pops for the cycle after reset release.
    assign fifo_rd_en = active & ~fifo_empty & (~word_vld | end_xfer | discard);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (xfer) begin
            state_nxt = (last && w_eof) ? ST_IDLE : ST_FRAME;
        end
    end

    always_comb begin
        ll_src_rdy = word_vld & ~discard;
        ll_sof     = ll_src_rdy & w_sof & (byte_idx == 2'd0);
        ll_err     = ll_sof & (state == ST_FRAME);
        ll_eof     = ll_src_rdy & w_eof & last;
        ll_data    = ll_src_rdy ? fifo_dout[{byte_sel, 3'b000} +: 8] : 8'h00;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active    <= 1'b0;
            word_vld  <= 1'b0;
            byte_idx  <= 2'd0;
            frame_cnt <= '0;
            drop_cnt  <= '0;
        end else begin
            active <= 1'b1;
            if (fifo_rd_en) begin
                word_vld <= 1'b1;
            end else if (end_xfer || discard) begin
                word_vld <= 1'b0;
            end
            if (end_xfer) begin
                byte_idx <= 2'd0;
            end else if (xfer) begin
                byte_idx <= byte_idx + 2'd1;
            end
            if (end_xfer && w_eof) begin
                frame_cnt <= frame_cnt + CNT_W'(1);
            end
            if (discard) begin
                drop_cnt <= drop_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fifo36_to_ll8_tx.sv
// tb/tb_fifo36_to_ll8_tx.sv - randomized self-checking bench for fifo36_to_ll8_tx
module tb_fifo36_to_ll8_tx;

    localparam int CNT_W = 16;
    localparam bit BE    = 1'b1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [35:0]      fifo_dout = '0;
    logic             fifo_empty = 1'b1;
    logic             fifo_rd_en;
    logic [7:0]       ll_data;
    logic             ll_sof, ll_eof, ll_err, ll_src_rdy;
    logic             ll_dst_rdy = 1'b0;
    logic [CNT_W-1:0] frame_cnt, drop_cnt;

    fifo36_to_ll8_tx #(.CNT_W(CNT_W), .BIG_ENDIAN(BE)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .ll_data    (ll_data),
        .ll_sof     (ll_sof),
        .ll_eof     (ll_eof),
        .ll_err     (ll_err),
        .ll_src_rdy (ll_src_rdy),
        .ll_dst_rdy (ll_dst_rdy),
        .frame_cnt  (frame_cnt),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: expected byte stream {data, sof, eof, err} and counters.
    logic [10:0] exp_q[$];
    logic [35:0] fq[$];
    logic [7:0]  byte_log[$];
    bit          m_in = 1'b0;
    int          exp_frames = 0;
    int          exp_drops = 0;

    function automatic void model_word(input logic [35:0] w);
        int  n;
        bit  sof, eof;
        logic [7:0] b;
        sof = w[32];
        eof = w[33];
        if (!m_in && !sof) begin
            exp_drops++;
            return;
        end
        n = eof ? ((w[35:34] == 2'd0) ? 4 : int'(w[35:34])) : 4;
        for (int k = 0; k < n; k++) begin
            b = BE ? w[(31 - 8*k) -: 8] : w[(8*k) +: 8];
            exp_q.push_back({b, sof && (k == 0), eof && (k == n-1), sof && (k == 0) && m_in});
        end
        if (eof) begin
            m_in = 1'b0;
            exp_frames++;
        end else begin
            m_in = 1'b1;
        end
    endfunction

    function automatic logic [35:0] mkw(input bit sof, input bit eof, input logic [1:0] occ,
                                        input logic [31:0] d);
        return {occ, eof, sof, d};
    endfunction

    task automatic push(input logic [35:0] w);
        fq.push_back(w);
        model_word(w);
    endtask

    // Standard-mode FIFO: data appears the cycle after the pop, empty lags a push by one cycle.
    always @(posedge clk) begin
        if (fifo_rd_en && fq.size() > 0) fifo_dout <= fq.pop_front();
        fifo_empty <= (fq.size() == 0);
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    int rdy_mode = 0;
    initial forever begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            0:       ll_dst_rdy = 1'b1;
            1:       ll_dst_rdy = ~ll_dst_rdy;
            default: ll_dst_rdy = ($urandom_range(0, 3) != 0);
        endcase
    end

    int          xfer_cnt = 0;
    int          rd_cnt = 0;
    int          first_xfer_cyc = -1;
    int          last_xfer_cyc = -1;
    bit          prev_stall = 1'b0;
    logic [10:0] prev_item = '0;

    always @(negedge clk) begin
        logic [10:0] cur;
        logic [10:0] e;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            cur = {ll_data, ll_sof, ll_eof, ll_err};
            check("rd_en_while_empty", fifo_rd_en & fifo_empty, 0);
            if (fifo_rd_en) rd_cnt++;
            if (prev_stall) begin
                check("stall_src_rdy", ll_src_rdy, 1);
                check("stall_hold", cur, prev_item);
            end
            if (ll_src_rdy && ll_dst_rdy) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_byte_q", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check("byte", cur, e);
                end
                byte_log.push_back(ll_data);
                xfer_cnt++;
                last_xfer_cyc = cyc;
                if (first_xfer_cyc < 0) first_xfer_cyc = cyc;
            end
            prev_stall = ll_src_rdy & ~ll_dst_rdy;
            prev_item  = cur;
        end
    end

    task automatic outputs_zero(input string tag);
        check({tag, "_rd_en"}, fifo_rd_en, 0);
        check({tag, "_src_rdy"}, ll_src_rdy, 0);
        check({tag, "_flags"}, {ll_sof, ll_eof, ll_err}, 0);
        check({tag, "_data"}, ll_data, 0);
        check({tag, "_counts"}, {frame_cnt, drop_cnt}, 0);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || fq.size() != 0) && n < 4000) begin
            @(posedge clk);
            n++;
        end
        repeat (6) @(posedge clk);
        #1;
        check({tag, "_drained"}, exp_q.size() + fq.size(), 0);
        check({tag, "_frame_cnt"}, frame_cnt, 16'(exp_frames));
        check({tag, "_drop_cnt"}, drop_cnt, 16'(exp_drops));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int base;
        int n;

        // Reset state, and no pop during reset even with data waiting.
        repeat (2) @(posedge clk);
        #1;
        push(mkw(1, 0, 2'd0, 32'h12345678));
        push(mkw(0, 0, 2'd0, 32'h9abcdef0));
        push(mkw(0, 1, 2'd2, 32'hcafe0000));
        repeat (3) @(posedge clk);
        #1;
        check("reset_fifo_not_empty", fifo_empty, 0);
        outputs_zero("reset");

        // 1: 3-word frame, EOF occ=2 -> 10 contiguous bytes.
        rdy_mode = 0;
        first_xfer_cyc = -1;
        byte_log.delete();
        rst_n = 1'b1;
        drain("t1");
        check("t1_bytes", byte_log.size(), 10);
        check("t1_no_gaps", last_xfer_cyc - first_xfer_cyc, 9);

        // 2: two 4-word frames back to back with the FIFO pre-filled.
        first_xfer_cyc = -1;
        rd_cnt = 0;
        for (int f = 0; f < 2; f++) begin
            for (int w = 0; w < 4; w++) push(mkw(w == 0, w == 3, 2'd0, $urandom));
        end
        drain("t2");
        check("t2_no_gaps", last_xfer_cyc - first_xfer_cyc, 31);
        check("t2_rd_cnt", rd_cnt, 8);

        // 3: alternating dst_rdy; byte order of 0x12345678.
        rdy_mode = 1;
        byte_log.delete();
        push(mkw(1, 1, 2'd0, 32'h12345678));
        push(mkw(1, 0, 2'd0, $urandom));
        push(mkw(0, 1, 2'd1, $urandom));
        drain("t3");
        check("t3_order", {byte_log[0], byte_log[1], byte_log[2], byte_log[3]}, 32'h12345678);

        // 4: two stray words dropped, then a 3-byte single-word frame.
        rdy_mode = 0;
        byte_log.delete();
        push(mkw(0, 0, 2'd0, $urandom));
        push(mkw(0, 1, 2'd1, $urandom));
        push(mkw(1, 1, 2'd3, 32'h01020304));
        drain("t4");
        check("t4_drops", drop_cnt, 2);
        check("t4_bytes", byte_log.size(), 3);

        // 5: SOF mid-frame raises err; only the EOF closes a frame.
        rdy_mode = 2;
        base = exp_frames;
        push(mkw(1, 0, 2'd0, $urandom));
        push(mkw(0, 0, 2'd0, $urandom));
        push(mkw(1, 0, 2'd0, $urandom));
        push(mkw(0, 0, 2'd0, $urandom));
        push(mkw(0, 1, 2'd1, $urandom));
        drain("t5");
        check("t5_frame_inc", frame_cnt, 16'(base + 1));

        // 6: reset during byte 2; leftover words are dropped afterwards.
        rdy_mode = 0;
        base = xfer_cnt;
        push(mkw(1, 0, 2'd0, $urandom));
        push(mkw(0, 0, 2'd0, $urandom));
        push(mkw(0, 0, 2'd0, $urandom));
        push(mkw(0, 1, 2'd0, $urandom));
        n = 0;
        while (xfer_cnt < base + 1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t6_started", xfer_cnt >= base + 1, 1);
        @(posedge clk);
        #1;
        check("t6_src_rdy_before", ll_src_rdy, 1);
        rst_n = 1'b0;
        #1;
        outputs_zero("t6_rst");
        exp_q.delete();
        m_in = 1'b0;
        exp_frames = 0;
        exp_drops = 0;
        foreach (fq[i]) model_word(fq[i]);
        repeat (2) @(posedge clk);
        #1;
        outputs_zero("t6_rst_hold");
        rst_n = 1'b1;
        push(mkw(1, 1, 2'd2, $urandom));
        drain("t6");
        check("t6_drops", drop_cnt, 3);
        check("t6_frames", frame_cnt, 1);

        // 7: random frames, strays, mid-frame SOFs, FIFO gaps and back-pressure.
        rdy_mode = 2;
        for (int f = 0; f < 30; f++) begin
            int len;
            if ($urandom_range(0, 3) == 0) push(mkw(0, $urandom_range(0, 1), 2'($urandom), $urandom));
            len = $urandom_range(1, 4);
            for (int w = 0; w < len; w++) begin
                bit sof;
                sof = (w == 0) || ($urandom_range(0, 9) == 0);
                push(mkw(sof, w == len - 1, 2'($urandom), $urandom));
                n = $urandom_range(0, 3);
                repeat (n) @(posedge clk);
                #1;
            end
        end
        drain("t7");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
